// File: rtl/bus_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_sequencer_if
//  Purpose  : Request/response and external memory bus signals of the sequencer.
//  Revision : 1.0
// ============================================================================
interface bus_sequencer_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ready;

    modport slave (
        input  req, we, addr, wdata, mem_din, mem_ready,
        output busy, done, err, rdata, mem_addr, mem_dout, mem_rd, mem_wr
    );

    modport master (
        output req, we, addr, wdata, mem_din, mem_ready,
        input  busy, done, err, rdata, mem_addr, mem_dout, mem_rd, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_sequencer
//  Purpose  : Runs one strobed byte cycle on the external memory bus per request,
//             with programmable wait states, ready handshake and timeout abort.
//  Revision : 1.0
// ============================================================================
module bus_sequencer #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    bus_sequencer_if.slave   bus
);

    localparam logic [3:0] c_wait_init = 4'(WAIT_STATES);
    localparam logic [7:0] c_timeout   = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            wait_cnt_q <= 4'd0;
            to_cnt_q   <= 8'd0;
            mem_addr_q <= 16'd0;
            mem_dout_q <= 8'd0;
            rdata_q    <= 8'd0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            rdata_q    <= rdata_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Strobes and done are registered so they change only on clock edges.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        rdata_d    = rdata_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    mem_addr_d = bus.addr;
                    mem_dout_d = bus.wdata;
                    we_d       = bus.we;
                    wait_cnt_d = c_wait_init;
                    to_cnt_d   = 8'd0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                mem_rd_d = ~we_q;
                mem_wr_d = we_q;
                state_d  = S_ACCESS;
            end
            S_ACCESS: begin
                mem_rd_d = mem_rd_q;
                mem_wr_d = mem_wr_q;
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else if (bus.mem_ready) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus.mem_din;
                    end
                    state_d = S_END;
                end else if (to_cnt_q >= c_timeout) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    if (!we_q) begin
                        rdata_d = 8'hFF;
                    end
                    state_d = S_END;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            S_END: begin
                to_cnt_d = 8'd0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_wr   = mem_wr_q;

endmodule
`default_nettype wire
